// File: rtl/rtc_bus_responder.sv
// RTC device model on a multiplexed active-low AD bus: synchronized strobe decode,
// a BCD time register file and a free-running one-second prescaler.
module rtc_bus_responder #(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic       ad,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       tick
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;
  state_t state;

  logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync, ad_sync;
  logic cs_s, rd_s, wr_s, ad_s;
  logic rd_prev, wr_prev, wr_rise, rd_fall;
  logic addr_commit, data_commit, read_start, read_hold;

  logic [7:0] addr, ctrl, sec, min, hour, day, month, year;
  logic [7:0] read_mux, last_day;
  logic [7:0] sec_n, min_n, hour_n, day_n, month_n, year_n;
  logic       c_sec, c_min, c_hour, c_day, c_month;
  logic [1:0] ymod;
  logic       leap;

  logic [PW-1:0] prescaler;
  logic          pending, wrap, step;

  // A field wraps at its limit, and also whenever it holds a non-decimal nibble.
  function automatic logic bcd_wraps(input logic [7:0] v, input logic [7:0] lim);
    return (v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v >= lim);
  endfunction

  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] lim,
                                          input logic [7:0] base);
    logic [7:0] r;
    if (bcd_wraps(v, lim))   r = base;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync <= '1;
      rd_sync <= '1;
      wr_sync <= '1;
      ad_sync <= '1;
      rd_prev <= 1'b1;
      wr_prev <= 1'b1;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], cs};
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], rd};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], wr};
      ad_sync <= {ad_sync[SYNC_STAGES-2:0], ad};
      rd_prev <= rd_s;
      wr_prev <= wr_s;
    end
  end

  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign rd_s    = rd_sync[SYNC_STAGES-1];
  assign wr_s    = wr_sync[SYNC_STAGES-1];
  assign ad_s    = ad_sync[SYNC_STAGES-1];
  assign wr_rise = wr_s & ~wr_prev;
  assign rd_fall = ~rd_s & rd_prev;

  assign addr_commit = (state == ADDR)  && wr_rise && !cs_s;
  assign data_commit = (state == WDATA) && wr_rise && !cs_s;
  assign read_start  = (state == IDLE)  && rd_fall && !cs_s && ad_s && wr_s;
  assign read_hold   = !cs_s && !rd_s && ad_s && wr_s;

  always_comb begin
    read_mux = 8'h00;
    case (addr)
      8'h00:   read_mux = ctrl;
      8'h21:   read_mux = sec;
      8'h22:   read_mux = min;
      8'h23:   read_mux = hour;
      8'h24:   read_mux = day;
      8'h25:   read_mux = month;
      8'h26:   read_mux = year;
      default: read_mux = 8'h00;
    endcase
  end

  // A pending write strobe outranks a read; the read snapshot is frozen while data_oe is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      data_out <= 8'h00;
      data_oe  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!cs_s && !wr_s) begin
            state <= ad_s ? WDATA : ADDR;
          end else if (read_start) begin
            state    <= RDATA;
            data_out <= read_mux;
            data_oe  <= 1'b1;
          end
        end
        ADDR, WDATA: begin
          if (cs_s || wr_rise) state <= IDLE;
        end
        RDATA: begin
          if (!read_hold) begin
            state   <= IDLE;
            data_oe <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Feb is leap when the two-digit BCD year is divisible by 4 (10 = 2 mod 4).
  assign ymod = year[1:0] + {year[4], 1'b0};
  assign leap = (ymod == 2'b00);

  always_comb begin
    last_day = 8'h31;
    case (month)
      8'h02:                      last_day = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: last_day = 8'h30;
      default:                    last_day = 8'h31;
    endcase
  end

  assign c_sec   = bcd_wraps(sec, 8'h59);
  assign sec_n   = bcd_step(sec, 8'h59, 8'h00);
  assign c_min   = c_sec && bcd_wraps(min, 8'h59);
  assign min_n   = c_sec ? bcd_step(min, 8'h59, 8'h00) : min;
  assign c_hour  = c_min && bcd_wraps(hour, 8'h23);
  assign hour_n  = c_min ? bcd_step(hour, 8'h23, 8'h00) : hour;
  assign c_day   = c_hour && bcd_wraps(day, last_day);
  assign day_n   = c_hour ? bcd_step(day, last_day, 8'h01) : day;
  assign c_month = c_day && bcd_wraps(month, 8'h12);
  assign month_n = c_day ? bcd_step(month, 8'h12, 8'h01) : month;
  assign year_n  = c_month ? bcd_step(year, 8'h99, 8'h00) : year;

  assign wrap = !ctrl[0] && (prescaler == PRE_MAX);
  assign step = (wrap && !data_commit) || pending;

  // A bus write colliding with a wrap wins; the increment and tick slip one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr      <= 8'h00;
      ctrl      <= 8'h00;
      sec       <= 8'h00;
      min       <= 8'h00;
      hour      <= 8'h00;
      day       <= 8'h01;
      month     <= 8'h01;
      year      <= 8'h00;
      prescaler <= '0;
      pending   <= 1'b0;
      tick      <= 1'b0;
    end else begin
      tick    <= 1'b0;
      pending <= wrap && data_commit;
      if (!ctrl[0]) prescaler <= wrap ? '0 : prescaler + 1'b1;
      if (addr_commit) addr <= data_in;
      if (step) begin
        sec   <= sec_n;
        min   <= min_n;
        hour  <= hour_n;
        day   <= day_n;
        month <= month_n;
        year  <= year_n;
        tick  <= 1'b1;
      end
      if (data_commit) begin
        case (addr)
          8'h00:   ctrl  <= data_in;
          8'h21:   sec   <= data_in;
          8'h22:   min   <= data_in;
          8'h23:   hour  <= data_in;
          8'h24:   day   <= data_in;
          8'h25:   month <= data_in;
          8'h26:   year  <= data_in;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder: bus phases, BCD rollover, read snapshot,
// write/tick collision, halt and reset behaviour.
module tb_rtc_bus_responder;

  localparam int T  = 40;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs, rd, wr, ad;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic       tick;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  int tick_count = 0;
  int last_tick_cyc = -1;

  rtc_bus_responder #(.TICK_CYCLES(T), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .ad(ad),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .tick(tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tick === 1'b1) begin
      tick_count    <= tick_count + 1;
      last_tick_cyc <= cyc;
    end
  end

  task automatic addr_phase(input logic [7:0] a);
    cs = 1'b0; ad = 1'b0; data_in = a; wr = 1'b0;
    repeat (4) @(negedge clk);
    wr = 1'b1;
    repeat (4) @(negedge clk);
    cs = 1'b1;
    @(negedge clk);
  endtask

  task automatic data_write(input logic [7:0] v);
    cs = 1'b0; ad = 1'b1; data_in = v; wr = 1'b0;
    repeat (4) @(negedge clk);
    wr = 1'b1;
    repeat (4) @(negedge clk);
    cs = 1'b1;
    @(negedge clk);
  endtask

  task automatic read_data(output logic [7:0] v);
    cs = 1'b0; ad = 1'b1; rd = 1'b0;
    repeat (4) @(negedge clk);
    v = data_oe ? data_out : 8'hxx;
    rd = 1'b1;
    repeat (4) @(negedge clk);
    cs = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] v);
    addr_phase(a);
    data_write(v);
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] v);
    addr_phase(a);
    read_data(v);
  endtask

  task automatic wait_tick(output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int n = 0; n < 3 * T; n++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  // Leaves the clock halted right after a tick, so the prescaler always freezes at the same count.
  task automatic halt_at_tick();
    bit ok;
    int at;
    wait_tick(ok, at);
    tests_run++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL halt_at_tick: no tick within %0d cycles, want one", 3 * T);
    end
    write_reg(8'h00, 8'h01);
  endtask

  task automatic run_one_tick(output int start, output int at);
    bit ok;
    start = cyc;
    write_reg(8'h00, 8'h00);
    wait_tick(ok, at);
    tests_run++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL run_one_tick: no tick within %0d cycles, want one", 3 * T);
    end
    write_reg(8'h00, 8'h01);
  endtask

  task automatic set_time(input logic [7:0] y, input logic [7:0] mo, input logic [7:0] d,
                          input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
    write_reg(8'h26, y);
    write_reg(8'h25, mo);
    write_reg(8'h24, d);
    write_reg(8'h23, h);
    write_reg(8'h22, mi);
    write_reg(8'h21, s);
  endtask

  task automatic check_reg(input string name, input logic [7:0] a, input logic [7:0] want);
    logic [7:0] v;
    read_reg(a, v);
    tests_run++;
    if (v !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %h want %h", name, v, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (data_oe !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_oe: got %b want 0", data_oe);
    end
    tests_run++;
    if (data_out !== 8'h00) begin
      fails++;
      $display("[TB] FAIL reset_dout: got %h want 00", data_out);
    end
    tests_run++;
    if (tick !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_tick: got %b want 0", tick);
    end
    reset = 1'b1;
    @(negedge clk);
    check_reg("reset_sec", 8'h21, 8'h00);
    check_reg("reset_day", 8'h24, 8'h01);
    check_reg("reset_month", 8'h25, 8'h01);
    check_reg("reset_ctrl", 8'h00, 8'h00);
  endtask

  task automatic test_rollover();
    int s, a;
    set_time(8'h00, 8'h01, 8'h01, 8'h23, 8'h59, 8'h59);
    run_one_tick(s, a);
    check_reg("roll_sec", 8'h21, 8'h00);
    check_reg("roll_min", 8'h22, 8'h00);
    check_reg("roll_hour", 8'h23, 8'h00);
    check_reg("roll_day", 8'h24, 8'h02);
  endtask

  task automatic test_calendar();
    int s, a;
    set_time(8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    run_one_tick(s, a);
    check_reg("leap_day29", 8'h24, 8'h29);
    check_reg("leap_month02", 8'h25, 8'h02);
    set_time(8'h24, 8'h02, 8'h29, 8'h23, 8'h59, 8'h59);
    run_one_tick(s, a);
    check_reg("leap_day01", 8'h24, 8'h01);
    check_reg("leap_month03", 8'h25, 8'h03);
    set_time(8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    run_one_tick(s, a);
    check_reg("noleap_day", 8'h24, 8'h01);
    check_reg("noleap_month", 8'h25, 8'h03);
    set_time(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
    run_one_tick(s, a);
    check_reg("newyear_year", 8'h26, 8'h00);
    check_reg("newyear_month", 8'h25, 8'h01);
    check_reg("newyear_day", 8'h24, 8'h01);
  endtask

  task automatic test_read_burst();
    int c, t0;
    logic [7:0] v;
    write_reg(8'h22, 8'h10);
    write_reg(8'h21, 8'h59);
    t0 = tick_count;
    c = cyc;
    write_reg(8'h00, 8'h00);
    addr_phase(8'h22);
    for (int n = 0; n < 2 * T && cyc < c + T - 5; n++) @(negedge clk);
    cs = 1'b0; ad = 1'b1; rd = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      tests_run++;
      if (data_oe !== (k >= SS + 1)) begin
        fails++;
        $display("[TB] FAIL burst_oe_%0d: got %b want %b", k, data_oe, (k >= SS + 1));
      end
      if (k >= SS + 1) begin
        tests_run++;
        if (data_out !== 8'h10) begin
          fails++;
          $display("[TB] FAIL burst_dout_%0d: got %h want 10", k, data_out);
        end
      end
    end
    rd = 1'b1;
    for (int m = 1; m <= 3; m++) begin
      @(negedge clk);
      tests_run++;
      if (data_oe !== (m < 3)) begin
        fails++;
        $display("[TB] FAIL burst_drop_%0d: got %b want %b", m, data_oe, (m < 3));
      end
    end
    cs = 1'b1;
    @(negedge clk);
    tests_run++;
    if (tick_count !== t0 + 1) begin
      fails++;
      $display("[TB] FAIL burst_ticks: got %0d want %0d", tick_count - t0, 1);
    end
    read_data(v);
    tests_run++;
    if (v !== 8'h11) begin
      fails++;
      $display("[TB] FAIL burst_min_after: got %h want 11", v);
    end
    halt_at_tick();
  endtask

  task automatic test_collision();
    int c, t0;
    logic [7:0] v;
    t0 = tick_count;
    c = cyc;
    write_reg(8'h00, 8'h00);
    addr_phase(8'h21);
    cs = 1'b0; ad = 1'b1; data_in = 8'h30; wr = 1'b0;
    for (int n = 0; n < 2 * T && cyc < c + T - 3; n++) @(negedge clk);
    wr = 1'b1;
    repeat (4) @(negedge clk);
    cs = 1'b1;
    @(negedge clk);
    tests_run++;
    if (tick_count !== t0 + 1) begin
      fails++;
      $display("[TB] FAIL coll_ticks: got %0d want 1", tick_count - t0);
    end
    tests_run++;
    if (last_tick_cyc !== c + T + 1) begin
      fails++;
      $display("[TB] FAIL coll_tick_time: got %0d want %0d", last_tick_cyc - c, T + 1);
    end
    read_data(v);
    tests_run++;
    if (v !== 8'h31) begin
      fails++;
      $display("[TB] FAIL coll_sec: got %h want 31", v);
    end
    halt_at_tick();
  endtask

  task automatic test_halt();
    int t0, s, a;
    logic [7:0] v;
    bit seen_oe;
    check_reg("halt_sec_before", 8'h21, 8'h32);
    t0 = tick_count;
    repeat (3 * T) @(negedge clk);
    tests_run++;
    if (tick_count !== t0) begin
      fails++;
      $display("[TB] FAIL halt_no_tick: got %0d ticks want 0", tick_count - t0);
    end
    read_data(v);
    tests_run++;
    if (v !== 8'h32) begin
      fails++;
      $display("[TB] FAIL halt_sec_stable: got %h want 32", v);
    end
    seen_oe = 1'b0;
    cs = 1'b0; ad = 1'b0; rd = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (data_oe !== 1'b0) seen_oe = 1'b1;
    end
    rd = 1'b1; cs = 1'b1; ad = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (seen_oe) begin
      fails++;
      $display("[TB] FAIL addr_read_oe: got 1 want 0");
    end
    run_one_tick(s, a);
    tests_run++;
    if (a - s !== T) begin
      fails++;
      $display("[TB] FAIL resume_delay: got %0d want %0d", a - s, T);
    end
    check_reg("resume_sec", 8'h21, 8'h33);
    write_reg(8'h7F, 8'h55);
    check_reg("unmapped_read", 8'h7F, 8'h00);
    check_reg("unmapped_ctrl", 8'h00, 8'h01);
    check_reg("unmapped_sec", 8'h21, 8'h33);
  endtask

  task automatic test_reset_mid_run();
    addr_phase(8'h21);
    cs = 1'b0; ad = 1'b1; data_in = 8'h77; wr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cs = 1'b1; wr = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (data_oe !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_reset_oe: got %b want 0", data_oe);
    end
    reset = 1'b1;
    @(negedge clk);
    check_reg("mid_reset_sec", 8'h21, 8'h00);
    check_reg("mid_reset_day", 8'h24, 8'h01);
    check_reg("mid_reset_ctrl", 8'h00, 8'h00);
  endtask

  initial begin
    reset = 1'b0; cs = 1'b1; rd = 1'b1; wr = 1'b1; ad = 1'b1; data_in = 8'h00;
    test_reset();
    halt_at_tick();
    test_rollover();
    test_calendar();
    test_read_burst();
    test_collision();
    test_halt();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
